// File: rtl/inst_rom_loader.sv
// Fetch-port instruction ROM with a byte-serial, big-endian image loader.
// Optional INST_ROM_CHECKSUM_EN gates cpu_run_o on a word checksum match.
module inst_rom_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_busy_o,
  output logic              cpu_run_o,
  output logic [ADDR_W:0]   ld_words_o,
`ifdef INST_ROM_CHECKSUM_EN
  input  logic [31:0]       exp_sum_i,
  output logic [31:0]       checksum_o,
`endif
  output logic              err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ADDR_W:0] r_wr_ptr;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_shift;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH];

  logic            w_full;
  logic            w_xfer;
  logic            w_wr;
  logic [31:0]     w_word;
  logic            w_sum_ok;
  logic [31:0]     w_off;
  logic            w_good;
  logic            w_fetch_ok;
  logic            w_fetch_bad;
  logic            w_ovf;
  logic            w_sum_bad;

  // Pointer never exceeds DEPTH, so its top bit alone means full.
  assign w_full = r_wr_ptr[ADDR_W];
  assign w_xfer = ld_valid_i && ld_ready_o;
  assign w_wr   = w_xfer && ((r_byte_cnt == 2'd3) || ld_last_i);

  always_comb begin
    w_word = '0;
    unique case (r_byte_cnt)
      2'd0:    w_word = {ld_byte_i, 24'h0};
      2'd1:    w_word = {r_shift[7:0], ld_byte_i, 16'h0};
      2'd2:    w_word = {r_shift[15:0], ld_byte_i, 8'h0};
      default: w_word = {r_shift, ld_byte_i};
    endcase
  end

`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sum <= '0;
    else if (w_wr) r_sum <= r_sum + w_word;
  end

  assign checksum_o = r_sum;
  assign w_sum_ok   = (r_sum == exp_sum_i);
`else
  assign w_sum_ok   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_FILL;
      S_FILL: begin
        if (w_xfer && ld_last_i) w_next = S_DONE;
        else if (w_full)         w_next = S_DONE;
      end
      default: w_next = S_DONE;
    endcase
  end

  always_comb begin
    ld_ready_o = (r_state == S_FILL) && !w_full;
    ld_busy_o  = (r_state == S_FILL);
    cpu_run_o  = (r_state == S_DONE) && w_sum_ok;
  end

  assign w_off       = rom_addr_i - BASE_ADDR;
  assign w_good      = (w_off[1:0] == 2'b00) && ~|w_off[31:ADDR_W+2];
  assign w_fetch_ok  = rom_ce_i && cpu_run_o && w_good;
  assign w_fetch_bad = rom_ce_i && cpu_run_o && !w_good;
  assign rom_data_o  = w_fetch_ok ? r_mem[w_off[ADDR_W+1:2]] : 32'h0;

  assign w_ovf     = (r_state == S_FILL) && w_full;
  assign w_sum_bad = (r_state == S_DONE) && !w_sum_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (w_wr) begin
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_byte_cnt <= '0;
          r_shift    <= '0;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_shift    <= {r_shift[15:0], ld_byte_i};
        end
      end
      if (w_ovf || w_fetch_bad || w_sum_bad) r_err <= 1'b1;
    end
  end

  // Array contents survive reset; only the write path is clocked.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_word;
  end

  assign ld_words_o = r_wr_ptr;
  assign err_o      = r_err;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader against an image-level model.
// Small array (4 words) so overflow and range edges are reachable.
module tb_inst_rom_loader;
  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rom_ce_i = 1'b0;
  logic [31:0]   rom_addr_i = '0;
  logic [31:0]   rom_data_o;
  logic          ld_valid_i = 1'b0;
  logic          ld_ready_o;
  logic [7:0]    ld_byte_i = '0;
  logic          ld_last_i = 1'b0;
  logic          ld_busy_o;
  logic          cpu_run_o;
  logic [AW:0]   ld_words_o;
  logic          err_o;
`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0]   exp_sum_i = '0;
  logic [31:0]   checksum_o;
`endif

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  bit          m_err;
  int          m_words;
  logic [31:0] m_sum;

  inst_rom_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_byte_i  (ld_byte_i),
    .ld_last_i  (ld_last_i),
    .ld_busy_o  (ld_busy_o),
    .cpu_run_o  (cpu_run_o),
    .ld_words_o (ld_words_o),
`ifdef INST_ROM_CHECKSUM_EN
    .exp_sum_i  (exp_sum_i),
    .checksum_o (checksum_o),
`endif
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ld_valid_i = 1'b0;
    ld_last_i = 1'b0;
    rom_ce_i = 1'b0;
    m_err = 1'b0;
    #1;
    check("rst_words", 32'(ld_words_o), 0);
    check("rst_run", 32'(cpu_run_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_ready", 32'(ld_ready_o), 0);
    check("rst_busy", 32'(ld_busy_o), 0);
`ifdef INST_ROM_CHECKSUM_EN
    check("rst_sum", checksum_o, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last,
                           output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    @(negedge clk);
    ld_valid_i = 1'b1;
    ld_byte_i = b;
    ld_last_i = last;
    while (!ld_ready_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (ld_ready_o) begin
      @(posedge clk);
      ok = 1'b1;
    end
    #1;
    ld_valid_i = 1'b0;
    ld_last_i = 1'b0;
  endtask

  // Model: bytes group big-endian into words, tail padded, truncated at DEPTH.
  task automatic load_image(input logic [7:0] b[$], input bit last);
    int nacc;
    bit ok;
    logic [31:0] w;
    nacc = (b.size() > 4*DEPTH) ? 4*DEPTH : b.size();
    m_words = last ? (nacc + 3) / 4 : nacc / 4;
    m_sum = '0;
    for (int i = 0; i < m_words; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < nacc) w[31-8*k -: 8] = b[4*i + k];
      m_mem[i] = w;
      m_vld[i] = 1'b1;
      m_sum += w;
    end
`ifdef INST_ROM_CHECKSUM_EN
    exp_sum_i = m_sum;
`endif
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(b[i], last && (i == b.size() - 1), ok);
      check("xfer", 32'(ok), 32'(i < nacc));
      if (!last && i == nacc - 1) check("ovf_ready", 32'(ld_ready_o), 0);
      if (last && i == b.size() - 1) check("run_now", 32'(cpu_run_o), 1);
    end
    if (!last && nacc == 4*DEPTH) m_err = 1'b1;
  endtask

  task automatic verify_done();
    repeat (2) @(negedge clk);
    check("words", 32'(ld_words_o), 32'(m_words));
    check("run", 32'(cpu_run_o), 1);
    check("busy", 32'(ld_busy_o), 0);
    check("ready", 32'(ld_ready_o), 0);
    check("err", 32'(err_o), 32'(m_err));
`ifdef INST_ROM_CHECKSUM_EN
    check("sum", checksum_o, m_sum);
`endif
  endtask

  task automatic fetch(input logic [31:0] a, input bit ce, input bit run);
    logic [31:0] off;
    logic [31:0] exp;
    bit good;
    bit do_chk;
    @(negedge clk);
    rom_ce_i = ce;
    rom_addr_i = a;
    off = a - BASE;
    good = (off % 4 == 0) && (off / 4 < 32'(DEPTH));
    exp = '0;
    do_chk = 1'b1;
    if (ce && run && good) begin
      if (m_vld[off / 4]) exp = m_mem[off / 4];
      else do_chk = 1'b0;
    end
    if (ce && run && !good) m_err = 1'b1;
    #1;
    if (do_chk) check("rom_data", rom_data_o, exp);
    @(posedge clk);
    #1;
    check("fetch_err", 32'(err_o), 32'(m_err));
    rom_ce_i = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    bit ok;
    int n;

    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_err = 1'b0;

    // Two-word image, then fetch and misalignment handling.
    do_reset();
    fetch(BASE + 32'd2, 1'b1, 1'b0);
    q = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h34, 8'h03, 8'h00, 8'h02};
    load_image(q, 1'b1);
    verify_done();
    check("d1_mem1", m_mem[1], 32'h3403_0002);
    fetch(BASE + 32'd4, 1'b1, 1'b1);
    fetch(BASE, 1'b1, 1'b1);
    fetch(BASE + 32'd2, 1'b0, 1'b1);
    fetch(BASE + 32'd2, 1'b1, 1'b1);
    fetch(BASE + 32'd4, 1'b1, 1'b1);

    // Partial last word is zero-padded.
    do_reset();
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load_image(q, 1'b1);
    verify_done();
    fetch(BASE + 32'd4, 1'b1, 1'b1);

    // Overflow: 20 bytes, no last.
    do_reset();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    load_image(q, 1'b0);
    verify_done();
    fetch(BASE + 32'd12, 1'b1, 1'b1);
    fetch(BASE + 32'd16, 1'b1, 1'b1);

    // Asynchronous reset mid-load discards the partial image.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, ok);
    #2 rst = 1'b0;
    #1;
    check("mid_words", 32'(ld_words_o), 0);
    check("mid_busy", 32'(ld_busy_o), 0);
    check("mid_run", 32'(cpu_run_o), 0);
    @(negedge clk);
    rst = 1'b1;
    m_err = 1'b0;
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_image(q, 1'b1);
    verify_done();
    fetch(BASE, 1'b1, 1'b1);

    // Random images and random fetches.
    for (int it = 0; it < 10; it++) begin
      do_reset();
      n = $urandom_range(1, 4*DEPTH);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      load_image(q, 1'b1);
      verify_done();
      for (int f = 0; f < 10; f++)
        fetch(BASE - 32'd8 + 32'($urandom_range(0, 31)),
              $urandom_range(0, 3) != 0, 1'b1);
    end

`ifdef INST_ROM_CHECKSUM_EN
    do_reset();
    q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    load_image(q, 1'b1);
    check("cs_sum3", m_sum, 32'd3);
    verify_done();
    do_reset();
    exp_sum_i = 32'd4;
    for (int i = 0; i < 8; i++) send_byte(q[i], i == 7, ok);
    repeat (2) @(negedge clk);
    check("cs_bad_run", 32'(cpu_run_o), 0);
    check("cs_bad_err", 32'(err_o), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder for the core's fetch port: it answers rom_ce/rom_addr with a combinational instruction word.
- Includes a byte-serial loader that fills the word array from an external byte stream (UART/JTAG bridge) before the core runs.
- Asserts cpu_run_o once loading completes; the top level holds the core in reset until then.

Parameters:
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words (default 1024 words = 4 KiB)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
rom_ce_i  in  1  fetch enable from core
rom_addr_i  in  32  fetch byte address (core PC)
rom_data_o  out  32  instruction word, combinational
ld_valid_i  in  1  loader byte valid
ld_ready_o  out  1  loader byte ready
ld_byte_i  in  8  loader byte
ld_last_i  in  1  marks final byte of image, qualified by ld_valid_i&&ld_ready_o
ld_busy_o  out  1  loader in FILL state
cpu_run_o  out  1  image loaded; core may leave reset
ld_words_o  out  ADDR_W+1  number of words written
err_o  out  1  sticky: misaligned/out-of-range fetch or image overflow

Behaviour:
- Reset (rst=0, async): state=IDLE, wr_ptr=0, byte_cnt=0, shift=0, ld_ready_o=0, ld_busy_o=0, cpu_run_o=0, ld_words_o=0, err_o=0. Array contents are not cleared.
- Byte transfer rule: a byte transfers on a clock edge with ld_valid_i&&ld_ready_o. ld_ready_o=1 only in FILL with wr_ptr<DEPTH.
- FSM states: IDLE -> FILL -> DONE.
- IDLE:
  - ld_ready_o=0.
  - Go to FILL on the first cycle after reset release, so the first byte may transfer one cycle after the reset-deassertion edge.
- FILL, word assembly:
  - Big-endian: first byte of each word lands in [31:24].
  - On each transfer: shift<={shift[23:0],byte}, byte_cnt++.
  - On the 4th byte (byte_cnt==3): write mem[wr_ptr]<={shift[23:0],byte} on the same edge, then wr_ptr++, byte_cnt<=0.
- FILL, ld_last_i with a partial word (byte_cnt+1<4): remaining low bytes are zero-padded; the word is written and wr_ptr++ on the same edge.
- FILL, ld_last_i accepted: go to DONE.
- FILL, overflow: when wr_ptr==DEPTH, ld_ready_o=0, err_o<=1 and the FSM goes to DONE (the image is truncated).
- DONE:
  - cpu_run_o=1, ld_ready_o=0, ld_busy_o=0.
  - Terminal until reset.
- ld_words_o = wr_ptr.
- Fetch path (combinational):
  - word index = (rom_addr_i-BASE_ADDR)>>2.
  - rom_data_o = mem[index] when rom_ce_i && cpu_run_o && addr[1:0]==0 && index<DEPTH; otherwise 32'h0 (NOP).
- err_o sets on the next edge when rom_ce_i && cpu_run_o && (misaligned || out of range). err_o is sticky until reset.
- While not in DONE, fetches return 0 and never set err_o.
- Array: single write port, single async read port (distributed RAM), no read-during-write hazard because reads are gated by DONE.
- Reset mid-load: state returns to IDLE, the pointer returns to 0, and the next image overwrites from word 0. A partially assembled word is discarded.

Optional Feature:
INST_ROM_CHECKSUM_EN
- Defined:
  - Adds output checksum_o[31:0], reset to 0.
  - On every array write, checksum_o <= checksum_o + written_word (mod 2^32, padded value for a partial last word).
  - In DONE, adds compare input exp_sum_i[31:0]: if checksum_o != exp_sum_i, err_o<=1 and cpu_run_o stays 0.
- Undefined: no checksum logic or ports; DONE always asserts cpu_run_o.

Test Plan:
- Stream 8 bytes 34 02 00 01 34 03 00 02 with ld_last on byte 8 -> mem[0]=32'h34020001, mem[1]=32'h34030002, ld_words_o=2, cpu_run_o=1 the cycle after the last byte; fetch addr 0x4 with ce=1 -> rom_data_o=32'h34030002.
- Stream 6 bytes AA BB CC DD 11 22 with last on 22 -> mem[1]=32'h11220000, ld_words_o=2.
- ADDR_W=2, stream 20 bytes without last -> after the 16th byte ld_ready_o=0, err_o=1, cpu_run_o=1, ld_words_o=4.
- After load, fetch addr 0x2 -> rom_data_o=0, err_o=1 the next cycle; with ce=0 -> rom_data_o=0 and no error.
- Assert rst=0 asynchronously after 5 bytes, release, then stream 4 bytes 01 02 03 04 with last -> mem[0]=32'h01020304, ld_words_o=1, err_o=0.
- With INST_ROM_CHECKSUM_EN, words 1 and 2 with exp_sum_i=3 -> cpu_run_o=1; with exp_sum_i=4 -> err_o=1, cpu_run_o=0.
